rambus2axibus: RTL and testbench

//  Store path of the cnna buffer engine. On ap_start, reads I_len words from an obuf RAM
//  (1-cycle read latency) and writes them to DDR at I_base_addr as one AXI4 INCR write burst.

---
 rtl/rambus2axibus_pkg.sv | 20 ++
 rtl/rambus2axibus_if.sv | 52 +++++
 rtl/rambus2axibus_rd_skid_fifo.sv | 37 +++
 rtl/rambus2axibus.sv | 142 ++++++++++++++
 tb/tb_rambus2axibus.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rambus2axibus_pkg.sv
// Shared AXI constants and FSM state encoding for the obuf-to-DDR store path.
package rambus2axibus_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned AXI4_MAX_BEATS = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_WDATA,
    S_WRESP,
    S_DONE
  } state_t;

  function automatic logic [2:0] axi_size(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/rambus2axibus_if.sv
// Control, obuf RAM read port and AXI4 write-channel signals of the store path.
interface rambus2axibus_if #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_RAM_ADDR_WIDTH   = 10,
  parameter int C_RAM_DATA_WIDTH   = 128
);
  logic                            I_ap_start;
  logic                            O_ap_done;
  logic                            O_ap_idle;
  logic                            O_ap_ready;
  logic                            O_err;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   I_base_addr;
  logic [C_RAM_ADDR_WIDTH-1:0]     I_len;
  logic [C_RAM_ADDR_WIDTH-1:0]     O_raddr;
  logic                            O_rd;
  logic [C_RAM_DATA_WIDTH-1:0]     I_rdata;
  logic [C_M_AXI_ID_WIDTH-1:0]     O_maxi_awid;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   O_maxi_awaddr;
  logic [7:0]                      O_maxi_awlen;
  logic [2:0]                      O_maxi_awsize;
  logic [1:0]                      O_maxi_awburst;
  logic                            O_maxi_awvalid;
  logic                            I_maxi_awready;
  logic [C_M_AXI_DATA_WIDTH-1:0]   O_maxi_wdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] O_maxi_wstrb;
  logic                            O_maxi_wlast;
  logic                            O_maxi_wvalid;
  logic                            I_maxi_wready;
  logic [1:0]                      I_maxi_bresp;
  logic                            I_maxi_bvalid;
  logic                            O_maxi_bready;

  modport master (
    input  I_ap_start, I_base_addr, I_len, I_rdata,
           I_maxi_awready, I_maxi_wready, I_maxi_bresp, I_maxi_bvalid,
    output O_ap_done, O_ap_idle, O_ap_ready, O_err, O_raddr, O_rd,
           O_maxi_awid, O_maxi_awaddr, O_maxi_awlen, O_maxi_awsize,
           O_maxi_awburst, O_maxi_awvalid, O_maxi_wdata, O_maxi_wstrb,
           O_maxi_wlast, O_maxi_wvalid, O_maxi_bready
  );

  modport slave (
    output I_ap_start, I_base_addr, I_len, I_rdata,
           I_maxi_awready, I_maxi_wready, I_maxi_bresp, I_maxi_bvalid,
    input  O_ap_done, O_ap_idle, O_ap_ready, O_err, O_raddr, O_rd,
           O_maxi_awid, O_maxi_awaddr, O_maxi_awlen, O_maxi_awsize,
           O_maxi_awburst, O_maxi_awvalid, O_maxi_wdata, O_maxi_wstrb,
           O_maxi_wlast, O_maxi_wvalid, O_maxi_bready
  );
endinterface

// File: rtl/rambus2axibus_rd_skid_fifo.sv
// Two-entry synchronous FIFO holding RAM read data plus its last-beat flag.
module rambus2axibus_rd_skid_fifo #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= '0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem[rp];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/rambus2axibus.sv
// Store path: streams I_len words from obuf RAM to DDR as one AXI4 INCR write burst.
module rambus2axibus
  import rambus2axibus_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_RAM_ADDR_WIDTH   = 10,
  parameter int C_RAM_DATA_WIDTH   = 128
) (
  input logic            I_clk,
  input logic            I_rst,
  rambus2axibus_if.master bus
);
  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int DW  = C_M_AXI_DATA_WIDTH;
  localparam int RAW = C_RAM_ADDR_WIDTH;
  localparam int RDW = C_RAM_DATA_WIDTH;
  localparam logic [RAW:0] MAX_LEN = (RAW+1)'(AXI4_MAX_BEATS);
  localparam logic [RAW:0] ONE     = (RAW+1)'(1);

  state_t         state, state_nx;
  logic [AW-1:0]  base_q;
  logic [RAW-1:0] len_q;
  logic [RAW:0]   len_m1;
  logic [RAW:0]   rcnt;
  logic           err_q;
  logic           rd_q, rd_last_q;
  logic           rd_en, rd_last, pop, start_ok, len_bad, len_zero;
  logic           fifo_empty;
  logic [1:0]     fifo_count;
  logic [2:0]     occ;
  logic [RDW:0]   fifo_dout;
  logic           awvalid, wvalid, bready, done, idle;

  assign start_ok = (state == S_IDLE) && bus.I_ap_start;
  assign len_bad  = {1'b0, bus.I_len} > MAX_LEN;
  assign len_zero = (bus.I_len == '0);
  assign len_m1   = {1'b0, len_q} - ONE;
  assign rd_last  = (rcnt == len_m1);
  assign pop      = (state == S_WDATA) && !fifo_empty && bus.I_maxi_wready;

  // Reads in flight plus queued words never exceed the two FIFO slots; a pop
  // in the same cycle frees one, which sustains one beat per clock.
  assign occ   = {1'b0, fifo_count} + {2'b0, rd_q};
  assign rd_en = ((state == S_AW) || (state == S_WDATA)) &&
                 (rcnt < {1'b0, len_q}) &&
                 ((occ - {2'b0, pop}) < 3'd2);

  always_ff @(posedge I_clk) begin
    if (I_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    bready   = 1'b0;
    done     = 1'b0;
    idle     = 1'b0;
    unique case (state)
      S_IDLE: begin
        idle = 1'b1;
        if (bus.I_ap_start) state_nx = (len_zero || len_bad) ? S_DONE : S_AW;
      end
      S_AW: begin
        awvalid = 1'b1;
        if (bus.I_maxi_awready) state_nx = S_WDATA;
      end
      S_WDATA: begin
        wvalid = !fifo_empty;
        if (pop && fifo_dout[RDW]) state_nx = S_WRESP;
      end
      S_WRESP: begin
        bready = 1'b1;
        if (bus.I_maxi_bvalid) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      base_q    <= '0;
      len_q     <= '0;
      rcnt      <= '0;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_q      <= rd_en;
      rd_last_q <= rd_en && rd_last;
      if (start_ok) begin
        base_q <= bus.I_base_addr;
        len_q  <= bus.I_len;
        rcnt   <= '0;
        err_q  <= len_bad;
      end else begin
        if (rd_en) rcnt <= rcnt + ONE;
        if ((state == S_WRESP) && bus.I_maxi_bvalid && (bus.I_maxi_bresp != AXI_RESP_OKAY))
          err_q <= 1'b1;
      end
    end
  end

  rambus2axibus_rd_skid_fifo #(
    .W(RDW + 1)
  ) U01_rd_skid_fifo (
    .clk  (I_clk),
    .rst  (I_rst),
    .push (rd_q),
    .pop  (pop),
    .din  ({rd_last_q, bus.I_rdata}),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign bus.O_ap_done      = done;
  assign bus.O_ap_ready     = done;
  assign bus.O_ap_idle      = idle;
  assign bus.O_err          = err_q;
  assign bus.O_raddr        = rcnt[RAW-1:0];
  assign bus.O_rd           = rd_en;
  assign bus.O_maxi_awid    = {C_M_AXI_ID_WIDTH{1'b0}};
  assign bus.O_maxi_awaddr  = base_q;
  assign bus.O_maxi_awlen   = len_m1[7:0];
  assign bus.O_maxi_awsize  = axi_size(DW / 8);
  assign bus.O_maxi_awburst = AXI_BURST_INCR;
  assign bus.O_maxi_awvalid = awvalid;
  assign bus.O_maxi_wdata   = fifo_dout[RDW-1:0];
  assign bus.O_maxi_wstrb   = {(DW/8){1'b1}};
  assign bus.O_maxi_wlast   = wvalid && fifo_dout[RDW];
  assign bus.O_maxi_wvalid  = wvalid;
  assign bus.O_maxi_bready  = bready;

endmodule

// File: tb/tb_rambus2axibus.sv
// Directed bench for rambus2axibus with a RAM model, AXI slave responder and beat scoreboard.
module tb_rambus2axibus;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rambus2axibus_if bus ();

  rambus2axibus dut (
    .I_clk(clk),
    .I_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [127:0] ram [1024];
  logic [128:0] beat_q [$];
  logic [31:0]  awaddr_q [$];
  logic [7:0]   awlen_q [$];

  int aw_delay = 0;
  int aw_cnt = 0;
  bit wtog = 1'b0;
  bit wphase = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;

  int beats = 0, aw_hs = 0, awv_cyc = 0, wv_cyc = 0;
  bit aw_seen = 1'b0, done_pending = 1'b0, prev_done = 1'b0;
  bit w_stall = 1'b0, aw_stall = 1'b0;
  logic [128:0] stall_w;
  logic [39:0]  stall_aw;

  // obuf RAM with one-cycle read latency
  always @(posedge clk) begin
    if (rst) bus.I_rdata <= '0;
    else if (bus.O_rd) bus.I_rdata <= ram[bus.O_raddr];
  end

  // AXI slave: inputs change 2 time units after the rising edge
  always @(posedge clk) begin
    #2;
    if (rst) begin
      bus.I_maxi_awready = 1'b0;
      bus.I_maxi_wready  = 1'b0;
      bus.I_maxi_bvalid  = 1'b0;
      bus.I_maxi_bresp   = 2'b00;
      aw_cnt = 0;
      wphase = 1'b0;
    end else begin
      if (bus.O_maxi_awvalid && !bus.I_maxi_awready) begin
        if (aw_cnt >= aw_delay) bus.I_maxi_awready = 1'b1;
        else aw_cnt++;
      end else begin
        bus.I_maxi_awready = 1'b0;
        aw_cnt = 0;
      end
      wphase = ~wphase;
      bus.I_maxi_wready = wtog ? wphase : 1'b1;
      bus.I_maxi_bvalid = bus.O_maxi_bready;
      bus.I_maxi_bresp  = bresp_cfg;
    end
  end

  // Channel monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      aw_seen = 1'b0; done_pending = 1'b0; prev_done = 1'b0;
      w_stall = 1'b0; aw_stall = 1'b0;
    end else begin
      if (done_pending) begin
        chk("done_after_bresp", bus.O_ap_done, 1);
        done_pending = 1'b0;
      end
      if (bus.O_ap_done) begin
        chk("done_single_cycle", prev_done, 0);
        chk("ready_with_done", bus.O_ap_ready, 1);
      end
      prev_done = bus.O_ap_done;
      if (aw_stall) begin
        chk("aw_hold_valid", bus.O_maxi_awvalid, 1);
        chk("aw_hold_addr_len", {bus.O_maxi_awaddr, bus.O_maxi_awlen}, stall_aw);
      end
      if (w_stall) begin
        chk("w_hold_valid", bus.O_maxi_wvalid, 1);
        chk("w_hold_data_last", {bus.O_maxi_wlast, bus.O_maxi_wdata}, stall_w);
      end
      if (bus.O_maxi_awvalid) awv_cyc++;
      if (bus.O_maxi_wvalid) begin
        wv_cyc++;
        chk("w_after_aw", aw_seen, 1);
      end
      if (bus.O_maxi_awvalid && bus.I_maxi_awready) begin
        if (awaddr_q.size() == 0) chk("aw_unexpected", awaddr_q.size(), 1);
        else begin
          chk("awaddr", bus.O_maxi_awaddr, awaddr_q.pop_front());
          chk("awlen", bus.O_maxi_awlen, awlen_q.pop_front());
        end
        chk("aw_static", {bus.O_maxi_awid, bus.O_maxi_awsize, bus.O_maxi_awburst}, {1'b0, 3'd4, 2'b01});
        aw_seen = 1'b1;
        aw_hs++;
      end
      if (bus.O_maxi_wvalid && bus.I_maxi_wready) begin
        if (beat_q.size() == 0) chk("w_unexpected", beat_q.size(), 1);
        else begin
          logic [128:0] e;
          e = beat_q.pop_front();
          chk("wdata", bus.O_maxi_wdata, e[127:0]);
          chk("wlast", bus.O_maxi_wlast, e[128]);
        end
        chk("wstrb", bus.O_maxi_wstrb, 16'hFFFF);
        beats++;
      end
      aw_stall = bus.O_maxi_awvalid && !bus.I_maxi_awready;
      stall_aw = {bus.O_maxi_awaddr, bus.O_maxi_awlen};
      w_stall  = bus.O_maxi_wvalid && !bus.I_maxi_wready;
      stall_w  = {bus.O_maxi_wlast, bus.O_maxi_wdata};
      if (bus.I_maxi_bvalid && bus.O_maxi_bready) begin
        done_pending = 1'b1;
        aw_seen = 1'b0;
      end
    end
  end

  task automatic expect_burst(input logic [31:0] base, input int len);
    awaddr_q.push_back(base);
    awlen_q.push_back(8'(len - 1));
    for (int i = 0; i < len; i++) beat_q.push_back({(i == len - 1), ram[i]});
  endtask

  task automatic run_xfer(input logic [31:0] base, input int len, input int awd,
                          input bit tog, input logic [1:0] br, output int cyc);
    logic exp_err;
    aw_delay = awd; wtog = tog; bresp_cfg = br;
    exp_err = (len > 256) || ((br != 2'b00) && (len >= 1));
    if (len >= 1 && len <= 256) expect_burst(base, len);
    @(negedge clk);
    bus.I_base_addr = base;
    bus.I_len = 10'(len);
    bus.I_ap_start = 1'b1;
    @(negedge clk);
    bus.I_ap_start = 1'b0;
    chk("err_after_start", bus.O_err, (len > 256));
    cyc = 1;
    while (!bus.O_ap_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", bus.O_ap_done, 1);
    chk("err_at_done", bus.O_err, exp_err);
    @(negedge clk);
    chk("done_dropped", bus.O_ap_done, 0);
    chk("idle_after_done", bus.O_ap_idle, 1);
    chk("beats_drained", beat_q.size(), 0);
    chk("aw_drained", awaddr_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, s_awv, s_wv, s_aw, b0, n, idl, dn;
    for (int i = 0; i < 1024; i++)
      ram[i] = {32'(i) ^ 32'hDEAD0000, ~32'(i), 32'(i * 7 + 3), 32'hC0DE0000 | 32'(i)};
    bus.I_ap_start = 1'b0;
    bus.I_base_addr = '0;
    bus.I_len = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_idle", bus.O_ap_idle, 1);
    chk("rst_done_ready", {bus.O_ap_done, bus.O_ap_ready}, 0);
    chk("rst_err", bus.O_err, 0);
    chk("rst_valids", {bus.O_maxi_awvalid, bus.O_maxi_wvalid, bus.O_maxi_wlast, bus.O_maxi_bready}, 0);
    chk("rst_rd", bus.O_rd, 0);
    rst = 1'b0;

    // basic burst, always-ready slave
    run_xfer(32'h1000, 4, 0, 1'b0, 2'b00, cyc);
    chk("len4_throughput", (cyc <= 9), 1);

    // delayed awready, toggling wready
    run_xfer(32'h2000, 16, 5, 1'b1, 2'b00, cyc);

    // single beat, then zero length
    run_xfer(32'h3000, 1, 0, 1'b0, 2'b00, cyc);
    s_awv = awv_cyc; s_wv = wv_cyc;
    run_xfer(32'h3100, 0, 0, 1'b0, 2'b00, cyc);
    chk("len0_latency", cyc, 1);
    chk("len0_no_axi", {32'(awv_cyc - s_awv), 32'(wv_cyc - s_wv)}, 0);

    // error response, clear on next start, oversize length
    run_xfer(32'h4000, 3, 0, 1'b0, 2'b10, cyc);
    run_xfer(32'h4100, 2, 0, 1'b0, 2'b00, cyc);
    s_awv = awv_cyc; s_wv = wv_cyc;
    run_xfer(32'h4200, 300, 0, 1'b0, 2'b00, cyc);
    chk("len300_no_axi", {32'(awv_cyc - s_awv), 32'(wv_cyc - s_wv)}, 0);
    run_xfer(32'h4300, 256, 0, 1'b0, 2'b00, cyc);

    // reset in the middle of the data phase
    aw_delay = 0; wtog = 1'b0; bresp_cfg = 2'b00;
    expect_burst(32'h5500, 16);
    @(negedge clk);
    bus.I_base_addr = 32'h5500; bus.I_len = 10'd16; bus.I_ap_start = 1'b1;
    @(negedge clk);
    bus.I_ap_start = 1'b0;
    b0 = beats; n = 0;
    while ((beats - b0) < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached", ((beats - b0) >= 5), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valids", {bus.O_maxi_awvalid, bus.O_maxi_wvalid, bus.O_maxi_wlast, bus.O_maxi_bready, bus.O_rd}, 0);
    chk("rst_mid_idle", bus.O_ap_idle, 1);
    rst = 1'b0;
    beat_q.delete(); awaddr_q.delete(); awlen_q.delete();
    run_xfer(32'h6000, 8, 0, 1'b0, 2'b00, cyc);

    // start held high across three transfers
    aw_delay = 1; wtog = 1'b0; bresp_cfg = 2'b00;
    for (int k = 0; k < 3; k++) expect_burst(32'h7000, 3);
    s_aw = aw_hs;
    @(negedge clk);
    bus.I_base_addr = 32'h7000; bus.I_len = 10'd3; bus.I_ap_start = 1'b1;
    idl = 0; dn = 0; n = 0;
    while (dn < 3 && n < 1000) begin
      @(negedge clk);
      n++;
      if (bus.O_ap_idle) idl++;
      if (bus.O_ap_done) dn++;
    end
    bus.I_ap_start = 1'b0;
    chk("held_done_pulses", dn, 3);
    chk("held_idle_between", idl, 2);
    repeat (4) @(negedge clk);
    chk("held_idle_end", bus.O_ap_idle, 1);
    chk("held_aw_count", aw_hs - s_aw, 3);
    chk("held_drained", {32'(beat_q.size()), 32'(awaddr_q.size())}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
